sdrc_port_arb: RTL and testbench
================================

# sdrc_port_arb

Four-port request arbiter and return-path router in front of the SDRAM controller application port (request generator input). Selects one requester at a time in round-robin order, forwards its request with the port index folded into the request ID, and routes per-port acks, read data and write-data strobes back. Write data ordering is tracked with a small in-order FIFO of granted write ports.

## Interface
- APP_AW, 26, application address width
- APP_RW, 9, request length width
- APP_DW, 64, data width
- APP_BW, 8, byte-enable width
- WFIFO_D, 4, write-order FIFO depth (power of 2)

- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- p_req  in  4  per-port request, held until p_ack
- p_tag  in  4*2  per-port local tag, port i at [2i+1:2i]
- p_addr  in  4*APP_AW  per-port address
- p_len  in  4*APP_RW  per-port burst length
- p_wr_n  in  4  0 write, 1 read
- p_wrap  in  4  wrap request
- p_wr_data  in  4*APP_DW  per-port write data
- p_wr_en_n  in  4*APP_BW  per-port byte enables (active-low)
- p_ack  out  4  one-cycle accept pulse, one-hot
- p_wr_next  out  4  per-port write-data advance
- p_rd_valid  out  4  per-port read data valid
- p_rd_last  out  4  per-port last read beat
- p_rd_tag  out  2  local tag of current read beat
- p_rd_data  out  APP_DW  read data, broadcast
- app_req  out  1  request to controller
- app_req_id  out  4  {port[1:0], tag[1:0]}
- app_req_addr  out  APP_AW
- app_req_len  out  APP_RW
- app_req_wr_n  out  1
- app_req_wrap  out  1
- app_req_ack  in  1  controller accepts request
- app_wr_next  in  1  controller consumes a write beat
- app_wr_last  in  1  last beat of current write burst (qualified by app_wr_next)
- app_wr_data  out  APP_DW  muxed write data
- app_wr_en_n  out  APP_BW  muxed byte enables
- app_rd_valid  in  1
- app_rd_last  in  1
- app_rd_id  in  4
- app_rd_data  in  APP_DW

## Operation
- States: IDLE, GRANT.
- IDLE: eligible = p_req & ~(p_wr_n==0 & wfifo_full) per port. If any eligible, pick first eligible after last_port (round-robin), register grant and muxed request fields, go GRANT. Else stay.
- GRANT: app_req=1 with registered fields. On app_req_ack: p_ack[grant]=1 (combinational, same cycle), last_port<=grant, push grant into write FIFO if write, go IDLE.
- Requester must hold p_req and fields stable until p_ack; arbiter does not re-sample fields in GRANT.
- Write path: app_wr_data/app_wr_en_n = port at FIFO head; p_wr_next[head] = app_wr_next; pop on app_wr_next & app_wr_last. FIFO empty: p_wr_next=0, app_wr_data=0, app_wr_en_n all 1.
- Read path: p_rd_valid[i] = app_rd_valid & (app_rd_id[3:2]==i); p_rd_last likewise; p_rd_tag = app_rd_id[1:0]; p_rd_data = app_rd_data. Pure combinational.
- Push and pop same cycle: both occur, count unchanged; push when full is impossible (gated in IDLE).
- app_wr_next with FIFO empty: ignored, no pop, no underflow.

## Timing
- Reset: state IDLE, app_req 0, all app_req_* fields 0, p_ack 0, last_port 3 (port 0 wins first), FIFO empty; all derived outputs follow.
- Latency: p_req rising in cycle N -> app_req in N+1; minimum ack in N+1 -> p_ack in N+1; next grant app_req earliest N+3 (one IDLE cycle between grants).
- app_req drops the cycle after app_req_ack.
- Reset mid-GRANT: request abandoned, no p_ack, FIFO cleared.
- Read/write strobe routing: zero cycle latency.

## Structure
- Package sdrc_arb_pkg: NPORT=4, PORT_W=2, TAG_W=2, state encoding.
- Sub-module sdrc_arb_fifo: WFIFO_D x PORT_W sync FIFO, push/pop/full/empty/head, async reset.
- Round-robin selector and muxes inline in sdrc_port_arb.

## Test plan
- All four ports request reads simultaneously, ack after 2 cycles each -> grants 0,1,2,3 in order; app_req_id 0x0_,0x4_,0x8_,0xC_ upper bits.
- Port 2 holds req continuously, port 1 requests after port 2 grant -> port 1 next, not port 2 again.
- Write grants from ports 3,1 (len 4 each), app_wr_next 8 beats with last on beats 4 and 8 -> p_wr_next[3] beats 1-4, p_wr_next[1] beats 5-8, data from matching port.
- Fill FIFO with 4 writes unpopped; port 0 write + port 1 read pending -> port 1 read granted, port 0 waits until one pop.
- app_rd_valid with id 0xB -> p_rd_valid=4'b0100, p_rd_tag=3; id 0x1 with last -> p_rd_last=4'b0001.
- Assert reset_n low during GRANT -> app_req 0 next edge, no p_ack, FIFO empty, first grant after release to lowest eligible port from 0.

Source files
------------

// File: rtl/sdrc_arb_pkg.sv
// Shared constants and state encoding for the SDRAM application-port arbiter.
package sdrc_arb_pkg;

    localparam int NPORT  = 4;
    localparam int PORT_W = 2;
    localparam int TAG_W  = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sdrc_arb_fifo.sv
// In-order FIFO of granted write ports; the head selects whose write data feeds the controller.
module sdrc_arb_fifo
    import sdrc_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = PORT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;

    // The extra pointer bit separates full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state pointers and storage; overflow and underflow requests are dropped.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/sdrc_port_arb.sv
// Four-port round-robin arbiter and return-path router in front of the SDRAM controller.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no request outstanding; pick next eligible port
//   ST_GRANT | registered request presented on app_req, waiting for ack
module sdrc_port_arb
    import sdrc_arb_pkg::*;
#(
    parameter int APP_AW  = 26,
    parameter int APP_RW  = 9,
    parameter int APP_DW  = 64,
    parameter int APP_BW  = 8,
    parameter int WFIFO_D = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NPORT-1:0]         p_req,
    input  logic [NPORT*TAG_W-1:0]   p_tag,
    input  logic [NPORT*APP_AW-1:0]  p_addr,
    input  logic [NPORT*APP_RW-1:0]  p_len,
    input  logic [NPORT-1:0]         p_wr_n,
    input  logic [NPORT-1:0]         p_wrap,
    input  logic [NPORT*APP_DW-1:0]  p_wr_data,
    input  logic [NPORT*APP_BW-1:0]  p_wr_en_n,
    output logic [NPORT-1:0]         p_ack,
    output logic [NPORT-1:0]         p_wr_next,
    output logic [NPORT-1:0]         p_rd_valid,
    output logic [NPORT-1:0]         p_rd_last,
    output logic [TAG_W-1:0]         p_rd_tag,
    output logic [APP_DW-1:0]        p_rd_data,
    output logic                     app_req,
    output logic [PORT_W+TAG_W-1:0]  app_req_id,
    output logic [APP_AW-1:0]        app_req_addr,
    output logic [APP_RW-1:0]        app_req_len,
    output logic                     app_req_wr_n,
    output logic                     app_req_wrap,
    input  logic                     app_req_ack,
    input  logic                     app_wr_next,
    input  logic                     app_wr_last,
    output logic [APP_DW-1:0]        app_wr_data,
    output logic [APP_BW-1:0]        app_wr_en_n,
    input  logic                     app_rd_valid,
    input  logic                     app_rd_last,
    input  logic [PORT_W+TAG_W-1:0]  app_rd_id,
    input  logic [APP_DW-1:0]        app_rd_data
);

    arb_state_e                 state_q, state_d;
    logic [PORT_W-1:0]          grant_q, grant_d;
    logic [PORT_W-1:0]          last_port_q, last_port_d;
    logic [PORT_W+TAG_W-1:0]    req_id_q, req_id_d;
    logic [APP_AW-1:0]          req_addr_q, req_addr_d;
    logic [APP_RW-1:0]          req_len_q, req_len_d;
    logic                       req_wr_n_q, req_wr_n_d;
    logic                       req_wrap_q, req_wrap_d;

    logic [NPORT-1:0]           eligible;
    logic [PORT_W-1:0]          rr_idx;
    logic [PORT_W-1:0]          rr_pick;
    logic                       wfifo_push;
    logic                       wfifo_pop;
    logic                       wfifo_full;
    logic                       wfifo_empty;
    logic [PORT_W-1:0]          wfifo_head;

    sdrc_arb_fifo #(.DEPTH(WFIFO_D), .W(PORT_W)) u_wfifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (wfifo_push),
        .push_data (grant_q),
        .pop       (wfifo_pop),
        .full      (wfifo_full),
        .empty     (wfifo_empty),
        .head      (wfifo_head)
    );

    // Round-robin pick: scan from last_port+1; writes are held off while the order FIFO is full.
    always_comb begin
        eligible = '0;
        rr_idx   = '0;
        rr_pick  = '0;
        for (int i = 0; i < NPORT; i++) begin
            eligible[i] = p_req[i] & ~(~p_wr_n[i] & wfifo_full);
        end
        for (int k = NPORT; k >= 1; k--) begin
            rr_idx = last_port_q + PORT_W'(k);
            if (eligible[rr_idx]) rr_pick = rr_idx;
        end
    end

    // FSM next state, request capture and ack generation.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_port_d = last_port_q;
        req_id_d    = req_id_q;
        req_addr_d  = req_addr_q;
        req_len_d   = req_len_q;
        req_wr_n_d  = req_wr_n_q;
        req_wrap_d  = req_wrap_q;
        p_ack       = '0;
        wfifo_push  = 1'b0;
        app_req     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    grant_d    = rr_pick;
                    req_id_d   = {rr_pick, p_tag[int'(rr_pick)*TAG_W +: TAG_W]};
                    req_addr_d = p_addr[int'(rr_pick)*APP_AW +: APP_AW];
                    req_len_d  = p_len[int'(rr_pick)*APP_RW +: APP_RW];
                    req_wr_n_d = p_wr_n[rr_pick];
                    req_wrap_d = p_wrap[rr_pick];
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                app_req = 1'b1;
                if (app_req_ack) begin
                    p_ack[grant_q] = 1'b1;
                    last_port_d    = grant_q;
                    wfifo_push     = ~req_wr_n_q;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and request-field registers; port 3 as last winner makes port 0 first after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_port_q <= PORT_W'(NPORT-1);
            req_id_q    <= '0;
            req_addr_q  <= '0;
            req_len_q   <= '0;
            req_wr_n_q  <= 1'b0;
            req_wrap_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_port_q <= last_port_d;
            req_id_q    <= req_id_d;
            req_addr_q  <= req_addr_d;
            req_len_q   <= req_len_d;
            req_wr_n_q  <= req_wr_n_d;
            req_wrap_q  <= req_wrap_d;
        end
    end

    assign app_req_id   = req_id_q;
    assign app_req_addr = req_addr_q;
    assign app_req_len  = req_len_q;
    assign app_req_wr_n = req_wr_n_q;
    assign app_req_wrap = req_wrap_q;

    assign wfifo_pop = app_wr_next & app_wr_last;

    // Write data and beat strobes follow the oldest granted write port.
    always_comb begin
        p_wr_next   = '0;
        app_wr_data = '0;
        app_wr_en_n = '1;
        if (!wfifo_empty) begin
            p_wr_next[wfifo_head] = app_wr_next;
            app_wr_data = p_wr_data[int'(wfifo_head)*APP_DW +: APP_DW];
            app_wr_en_n = p_wr_en_n[int'(wfifo_head)*APP_BW +: APP_BW];
        end
    end

    // Read beats are steered by the port index carried in the upper ID bits.
    always_comb begin
        p_rd_valid = '0;
        p_rd_last  = '0;
        for (int i = 0; i < NPORT; i++) begin
            p_rd_valid[i] = app_rd_valid & (app_rd_id[PORT_W+TAG_W-1:TAG_W] == PORT_W'(i));
            p_rd_last[i]  = app_rd_last  & (app_rd_id[PORT_W+TAG_W-1:TAG_W] == PORT_W'(i));
        end
    end

    assign p_rd_tag  = app_rd_id[TAG_W-1:0];
    assign p_rd_data = app_rd_data;

endmodule

// File: tb/tb_sdrc_port_arb.sv
// Directed and randomized checks of sdrc_port_arb against a queue-based reference model.
module tb_sdrc_port_arb;

    localparam int AW = 26;
    localparam int RW = 9;
    localparam int DW = 64;
    localparam int BW = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [3:0]        p_req, p_wr_n, p_wrap;
    logic [7:0]        p_tag;
    logic [4*AW-1:0]   p_addr;
    logic [4*RW-1:0]   p_len;
    logic [4*DW-1:0]   p_wr_data;
    logic [4*BW-1:0]   p_wr_en_n;
    logic [3:0]        p_ack, p_wr_next, p_rd_valid, p_rd_last;
    logic [1:0]        p_rd_tag;
    logic [DW-1:0]     p_rd_data;
    logic              app_req;
    logic [3:0]        app_req_id;
    logic [AW-1:0]     app_req_addr;
    logic [RW-1:0]     app_req_len;
    logic              app_req_wr_n, app_req_wrap;
    logic              app_req_ack, app_wr_next, app_wr_last;
    logic [DW-1:0]     app_wr_data;
    logic [BW-1:0]     app_wr_en_n;
    logic              app_rd_valid, app_rd_last;
    logic [3:0]        app_rd_id;
    logic [DW-1:0]     app_rd_data;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending grant (-1 when none), last winner, queue of write ports.
    int            m_pend;
    int            m_last;
    int            m_q[$];
    logic [3:0]    m_id;
    logic [AW-1:0] m_addr;
    logic [RW-1:0] m_len;
    logic          m_wr_n, m_wrap;

    sdrc_port_arb dut (
        .clk(clk), .reset_n(reset_n),
        .p_req(p_req), .p_tag(p_tag), .p_addr(p_addr), .p_len(p_len),
        .p_wr_n(p_wr_n), .p_wrap(p_wrap), .p_wr_data(p_wr_data), .p_wr_en_n(p_wr_en_n),
        .p_ack(p_ack), .p_wr_next(p_wr_next), .p_rd_valid(p_rd_valid), .p_rd_last(p_rd_last),
        .p_rd_tag(p_rd_tag), .p_rd_data(p_rd_data),
        .app_req(app_req), .app_req_id(app_req_id), .app_req_addr(app_req_addr),
        .app_req_len(app_req_len), .app_req_wr_n(app_req_wr_n), .app_req_wrap(app_req_wrap),
        .app_req_ack(app_req_ack), .app_wr_next(app_wr_next), .app_wr_last(app_wr_last),
        .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
        .app_rd_valid(app_rd_valid), .app_rd_last(app_rd_last), .app_rd_id(app_rd_id),
        .app_rd_data(app_rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int i, input logic wr_n, input int len);
        p_req[i]              = 1'b1;
        p_wr_n[i]             = wr_n;
        p_wrap[i]             = 1'($urandom_range(0, 1));
        p_tag[2*i +: 2]       = 2'($urandom_range(0, 3));
        p_addr[i*AW +: AW]    = AW'($urandom);
        p_len[i*RW +: RW]     = RW'(len);
        p_wr_data[i*DW +: DW] = {$urandom, $urandom};
        p_wr_en_n[i*BW +: BW] = BW'($urandom);
    endtask

    // One clock: check all outputs against the model, advance the model, clock, retire acked requests.
    task automatic step();
        logic [3:0] exp_ack;
        logic [3:0] exp_wn;
        logic [3:0] exp_rv;
        logic [3:0] exp_rl;
        logic       full;
        logic       do_pop;
        int         h;
        int         p;
        #1;
        if (!reset_n) begin
            m_pend = -1;
            m_last = 3;
            m_q.delete();
        end
        exp_ack = '0;
        if (reset_n && m_pend >= 0 && app_req_ack) exp_ack[m_pend] = 1'b1;
        chk("app_req", app_req, m_pend >= 0);
        if (m_pend >= 0) begin
            chk("req_id", app_req_id, m_id);
            chk("req_addr", app_req_addr, m_addr);
            chk("req_len", app_req_len, m_len);
            chk("req_wr_n", app_req_wr_n, m_wr_n);
            chk("req_wrap", app_req_wrap, m_wrap);
        end
        chk("p_ack", p_ack, exp_ack);
        exp_wn = '0;
        if (m_q.size() == 0) begin
            chk("wr_data_empty", app_wr_data, 64'd0);
            chk("wr_en_empty", app_wr_en_n, {BW{1'b1}});
        end else begin
            h = m_q[0];
            if (app_wr_next) exp_wn[h] = 1'b1;
            chk("wr_data", app_wr_data, p_wr_data[h*DW +: DW]);
            chk("wr_en", app_wr_en_n, p_wr_en_n[h*BW +: BW]);
        end
        chk("p_wr_next", p_wr_next, exp_wn);
        exp_rv = '0;
        exp_rl = '0;
        if (app_rd_valid) exp_rv[int'(app_rd_id) / 4] = 1'b1;
        if (app_rd_last)  exp_rl[int'(app_rd_id) / 4] = 1'b1;
        chk("rd_valid", p_rd_valid, exp_rv);
        chk("rd_last", p_rd_last, exp_rl);
        chk("rd_tag", p_rd_tag, int'(app_rd_id) % 4);
        chk("rd_data", p_rd_data, app_rd_data);
        if (reset_n) begin
            full   = (m_q.size() == 4);
            do_pop = app_wr_next && app_wr_last && (m_q.size() > 0);
            if (m_pend < 0) begin
                for (int k = 1; k <= 4; k++) begin
                    p = (m_last + k) % 4;
                    if (m_pend < 0 && p_req[p] && !(p_wr_n[p] == 1'b0 && full)) m_pend = p;
                end
                if (m_pend >= 0) begin
                    m_id   = {2'(m_pend), p_tag[2*m_pend +: 2]};
                    m_addr = p_addr[m_pend*AW +: AW];
                    m_len  = p_len[m_pend*RW +: RW];
                    m_wr_n = p_wr_n[m_pend];
                    m_wrap = p_wrap[m_pend];
                end
            end else if (app_req_ack) begin
                m_last = m_pend;
                if (!m_wr_n) m_q.push_back(m_pend);
                m_pend = -1;
            end
            if (do_pop) void'(m_q.pop_front());
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (exp_ack[i]) p_req[i] = 1'b0;
    endtask

    initial begin
        m_pend = -1; m_last = 3;
        reset_n = 1'b0;
        p_req = '0; p_wr_n = '1; p_wrap = '0; p_tag = '0; p_addr = '0; p_len = '0;
        p_wr_data = '0; p_wr_en_n = '1;
        app_req_ack = 1'b0; app_wr_next = 1'b0; app_wr_last = 1'b0;
        app_rd_valid = 1'b0; app_rd_last = 1'b0; app_rd_id = '0; app_rd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_app_req", app_req, 1'b0);
        chk("rst_req_id", app_req_id, 4'h0);
        chk("rst_req_addr", app_req_addr, '0);
        chk("rst_req_len", app_req_len, '0);
        chk("rst_req_flags", {app_req_wr_n, app_req_wrap}, 2'b00);
        chk("rst_p_ack", p_ack, 4'b0000);
        chk("rst_wr_en", app_wr_en_n, {BW{1'b1}});
        step();
        reset_n = 1'b1;

        // All four ports read at once: grants 0,1,2,3 with one IDLE cycle between.
        for (int i = 0; i < 4; i++) set_port(i, 1'b1, 8);
        step();
        for (int k = 0; k < 4; k++) begin
            chk("rr_order", app_req_id[3:2], k);
            app_req_ack = 1'b0; step();
            app_req_ack = 1'b1; step();
            app_req_ack = 1'b0; step();
        end

        // Port 2 re-requests immediately; port 1 must win next.
        set_port(2, 1'b1, 4);
        step();
        chk("hold_first", app_req_id[3:2], 2);
        app_req_ack = 1'b1; step();
        app_req_ack = 1'b0;
        set_port(2, 1'b1, 4);
        set_port(1, 1'b1, 4);
        step();
        chk("fair_next", app_req_id[3:2], 1);
        app_req_ack = 1'b1; step();
        app_req_ack = 1'b0; step();
        chk("fair_then", app_req_id[3:2], 2);
        app_req_ack = 1'b1; step();
        app_req_ack = 1'b0;

        // Writes from ports 3 then 1; beats 1-4 to port 3, 5-8 to port 1.
        set_port(3, 1'b0, 4);
        step();
        app_req_ack = 1'b1; step();
        app_req_ack = 1'b0;
        set_port(1, 1'b0, 4);
        step();
        app_req_ack = 1'b1; step();
        app_req_ack = 1'b0;
        for (int b = 0; b < 8; b++) begin
            app_wr_next = 1'b1;
            app_wr_last = (b == 3 || b == 7);
            #1;
            chk("wr_order", p_wr_next, (b < 4) ? 4'b1000 : 4'b0010);
            chk("wr_order_data", app_wr_data, p_wr_data[((b < 4) ? 3 : 1)*DW +: DW]);
            step();
        end
        app_wr_next = 1'b0; app_wr_last = 1'b0;
        step();
        chk("wr_drained_en", app_wr_en_n, {BW{1'b1}});

        // Fill the order FIFO, then a pending write must wait while a read goes through.
        for (int i = 0; i < 4; i++) set_port(i, 1'b0, 1);
        step();
        for (int k = 0; k < 4; k++) begin
            app_req_ack = 1'b1; step();
            app_req_ack = 1'b0; step();
        end
        set_port(0, 1'b0, 1);
        set_port(1, 1'b1, 2);
        step();
        chk("full_read_wins", app_req_id[3:2], 1);
        app_req_ack = 1'b1; step();
        app_req_ack = 1'b0; step();
        chk("full_write_waits", app_req, 1'b0);
        step();
        chk("full_write_waits2", app_req, 1'b0);
        app_wr_next = 1'b1; app_wr_last = 1'b1; step();
        app_wr_next = 1'b0; app_wr_last = 1'b0; step();
        chk("write_after_pop", app_req_id[3:2], 0);
        app_req_ack = 1'b1; step();
        app_req_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            app_wr_next = 1'b1; app_wr_last = (m_q.size() > 0);
            step();
        end
        app_wr_next = 1'b1; app_wr_last = 1'b1;
        step();
        app_wr_next = 1'b0; app_wr_last = 1'b0;

        // Read routing.
        app_rd_valid = 1'b1; app_rd_id = 4'hB; app_rd_data = {$urandom, $urandom};
        #1;
        chk("rd_route_b", p_rd_valid, 4'b0100);
        chk("rd_tag_b", p_rd_tag, 2'd3);
        step();
        app_rd_id = 4'h1; app_rd_last = 1'b1;
        #1;
        chk("rd_last_1", p_rd_last, 4'b0001);
        step();
        app_rd_valid = 1'b0; app_rd_last = 1'b0;

        // Reset while granting: no ack, FIFO cleared, port 0 first afterwards.
        set_port(1, 1'b0, 2);
        step();
        app_req_ack = 1'b1; step();
        app_req_ack = 1'b0;
        set_port(0, 1'b1, 2);
        set_port(2, 1'b1, 2);
        step();
        chk("pre_rst_grant", app_req_id[3:2], 2);
        app_req_ack = 1'b1; app_wr_next = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_req", app_req, 1'b0);
        chk("rst_mid_ack", p_ack, 4'b0000);
        chk("rst_mid_fifo", p_wr_next, 4'b0000);
        step();
        app_req_ack = 1'b0; app_wr_next = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_grant", app_req_id[3:2], 0);
        app_req_ack = 1'b1; step();
        app_req_ack = 1'b0; step();
        app_req_ack = 1'b1; step();
        app_req_ack = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            app_req_ack  = 1'($urandom_range(0, 1));
            app_wr_next  = 1'($urandom_range(0, 1));
            app_wr_last  = ($urandom_range(0, 3) == 0);
            app_rd_valid = 1'($urandom_range(0, 1));
            app_rd_last  = 1'($urandom_range(0, 1));
            app_rd_id    = 4'($urandom_range(0, 15));
            app_rd_data  = {$urandom, $urandom};
            for (int i = 0; i < 4; i++) begin
                if (!p_req[i] && $urandom_range(0, 2) == 0)
                    set_port(i, 1'($urandom_range(0, 1)), $urandom_range(1, 16));
                p_wr_data[i*DW +: DW] = {$urandom, $urandom};
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
